// File: rtl/linked_list_sched.sv
// Round-robin push/pop scheduler for the shared-memory N-list linked list, with drain mode.
// Zero latency: commands are combinational from inputs and state; pushes stall while ll_full or draining.
// Optional LLSCHED_STATS_EN adds stall_cnt, a saturating count of cycles a push request met ll_full.
module linked_list_sched #(
    parameter int NUM_ELEMS  = 4,
    parameter int NUM_LISTS  = 2,
    parameter int SEL_WIDTH  = $clog2(NUM_LISTS),
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_LISTS-1:0]  push_req,
    output logic [NUM_LISTS-1:0]  push_gnt,
    input  logic                  pop_en,
    output logic                  pop_valid,
    output logic [SEL_WIDTH-1:0]  pop_list,
    input  logic                  drain,
    output logic                  drain_done,
    input  logic                  ll_full,
    input  logic [NUM_LISTS-1:0]  ll_empty,
    output logic                  ll_push,
    output logic                  ll_pop,
    output logic [SEL_WIDTH-1:0]  ll_push_sel,
    output logic [SEL_WIDTH-1:0]  ll_pop_sel
`ifdef LLSCHED_STATS_EN
    ,output logic [STAT_WIDTH-1:0] stall_cnt
`endif
);

    if (NUM_LISTS < 2 || NUM_ELEMS < 1 || STAT_WIDTH < 1) begin : g_param_check
        $error("linked_list_sched: illegal parameters");
    end

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] push_ptr_q, push_ptr_d;
    logic [SEL_WIDTH-1:0] pop_ptr_q, pop_ptr_d;
    logic [SEL_WIDTH-1:0] push_win, pop_win;
    logic                 push_ok, pop_ok;

    // First set bit of mask at or after ptr, wrapping; callers only use it when mask is non-zero.
    function automatic logic [SEL_WIDTH-1:0] rr_pick(input logic [NUM_LISTS-1:0] mask,
                                                      input logic [SEL_WIDTH-1:0] ptr);
        logic [SEL_WIDTH-1:0] pick;
        logic [SEL_WIDTH-1:0] idx;
        logic                 found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_LISTS; k++) begin
            idx = SEL_WIDTH'((int'(ptr) + k) % NUM_LISTS);
            if (!found && mask[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [SEL_WIDTH-1:0] rr_next(input logic [SEL_WIDTH-1:0] win);
        return (win == SEL_WIDTH'(NUM_LISTS - 1)) ? '0 : win + SEL_WIDTH'(1);
    endfunction

    always_comb begin
        push_win = rr_pick(push_req, push_ptr_q);
        pop_win  = rr_pick(~ll_empty, pop_ptr_q);
        // rst_n gates the commands so reset silences the list without waiting for a clock.
        push_ok  = rst_n && (state_q == ST_RUN) && !ll_full && (|push_req);
        pop_ok   = rst_n && (state_q != ST_DONE) && pop_en && (~ll_empty != '0);

        ll_push     = push_ok;
        ll_push_sel = push_ok ? push_win : push_ptr_q;
        push_gnt    = push_ok ? (NUM_LISTS'(1) << push_win) : '0;
        ll_pop      = pop_ok;
        ll_pop_sel  = pop_ok ? pop_win : pop_ptr_q;
        pop_valid   = pop_ok;
        pop_list    = ll_pop_sel;
        drain_done  = rst_n && (state_q == ST_DONE);

        push_ptr_d  = push_ok ? rr_next(push_win) : push_ptr_q;
        pop_ptr_d   = pop_ok  ? rr_next(pop_win)  : pop_ptr_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain)                      state_d = ST_RUN;
                else if ((&ll_empty) && !pop_ok) state_d = ST_DONE;
            end
            ST_DONE:  if (!drain) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            push_ptr_q <= '0;
            pop_ptr_q  <= '0;
        end else begin
            state_q    <= state_d;
            push_ptr_q <= push_ptr_d;
            pop_ptr_q  <= pop_ptr_d;
        end
    end

`ifdef LLSCHED_STATS_EN
    logic [STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_RUN) && (|push_req) && ll_full && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STAT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_linked_list_sched.sv
// Directed bench for linked_list_sched with a behavioural occupancy model of the linked list.
module tb_linked_list_sched;
    localparam int NL = 2;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NL-1:0] push_req;
    logic [NL-1:0] push_gnt;
    logic          pop_en;
    logic          pop_valid;
    logic          pop_list;
    logic          drain;
    logic          drain_done;
    logic          ll_full;
    logic [NL-1:0] ll_empty;
    logic          ll_push, ll_pop;
    logic          ll_push_sel, ll_pop_sel;
`ifdef LLSCHED_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cnt[NL];

    always #5 clk = ~clk;

    linked_list_sched #(.NUM_ELEMS(NE), .NUM_LISTS(NL)) dut (
        .clk(clk), .rst_n(rst_n), .push_req(push_req), .push_gnt(push_gnt),
        .pop_en(pop_en), .pop_valid(pop_valid), .pop_list(pop_list),
        .drain(drain), .drain_done(drain_done), .ll_full(ll_full), .ll_empty(ll_empty),
        .ll_push(ll_push), .ll_pop(ll_pop), .ll_push_sel(ll_push_sel), .ll_pop_sel(ll_pop_sel)
`ifdef LLSCHED_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Linked-list occupancy model: registers commands at the same edge as the real list.
    assign ll_full     = (cnt[0] + cnt[1]) >= NE;
    assign ll_empty[0] = (cnt[0] == 0);
    assign ll_empty[1] = (cnt[1] == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt[0] <= 0;
            cnt[1] <= 0;
        end else begin
            for (int i = 0; i < NL; i++)
                cnt[i] <= cnt[i] + ((ll_push && ll_push_sel == i) ? 1 : 0)
                                 - ((ll_pop && ll_pop_sel == i) ? 1 : 0);
        end
    end

    // Protocol invariants checked on every issued command.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && (ll_push || ll_pop)) begin
            n_chk++;
            if ((ll_push && ll_full) || (ll_pop && ll_empty[ll_pop_sel]) ||
                ($countones(push_gnt) > 1) || (ll_push != (|push_gnt)) || (pop_valid != ll_pop)) begin
                n_fail++;
                $display("FAIL invariant: push=%b full=%b pop=%b pop_sel=%0d empty=%b gnt=%b pop_valid=%b",
                         ll_push, ll_full, ll_pop, ll_pop_sel, ll_empty, push_gnt, pop_valid);
            end
        end
    end

    task automatic drive(input logic [NL-1:0] pr, input logic pe, input logic dr);
        @(negedge clk);
        push_req = pr;
        pop_en   = pe;
        drain    = dr;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; push_req = '0; pop_en = 1'b0; drain = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push_req = 2'b11; pop_en = 1'b1; drain = 1'b0;
        #12;
        n_chk++; if (push_gnt !== 2'b00 || ll_push !== 1'b0) begin n_fail++; $display("FAIL reset_push: gnt=%b push=%b want 00/0", push_gnt, ll_push); end
        n_chk++; if (ll_pop !== 1'b0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pop: pop=%b valid=%b want 0/0", ll_pop, pop_valid); end
        n_chk++; if (drain_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", drain_done); end
        n_chk++; if (ll_push_sel !== 1'b0 || ll_pop_sel !== 1'b0 || pop_list !== 1'b0) begin n_fail++; $display("FAIL reset_sel: push_sel=%b pop_sel=%b pop_list=%b want 0", ll_push_sel, ll_pop_sel, pop_list); end
`ifdef LLSCHED_STATS_EN
        n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1; push_req = '0; pop_en = 1'b0;
    endtask

    task automatic test_fill();
        logic [NL-1:0] exp_gnt[4];
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 1'b0, 1'b0);
            n_chk++; if (push_gnt !== exp_gnt[k] || ll_push_sel !== exp_gnt[k][1]) begin n_fail++; $display("FAIL fill_gnt[%0d]: gnt=%b sel=%b want %b", k, push_gnt, ll_push_sel, exp_gnt[k]); end
        end
        drive(2'b11, 1'b0, 1'b0);
        n_chk++; if (push_gnt !== 2'b00 || ll_push !== 1'b0) begin n_fail++; $display("FAIL fill_full_block: gnt=%b push=%b want 00/0", push_gnt, ll_push); end
        drive(2'b00, 1'b0, 1'b0);
`ifdef LLSCHED_STATS_EN
        n_chk++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL fill_stall: got %0d want 1", stall_cnt); end
`endif
    endtask

    task automatic test_full_pop();
        drive(2'b01, 1'b1, 1'b0);
        n_chk++; if (ll_pop !== 1'b1 || ll_push !== 1'b0 || pop_list !== 1'b0) begin n_fail++; $display("FAIL fullpop_same: pop=%b push=%b list=%b want 1/0/0", ll_pop, ll_push, pop_list); end
        drive(2'b01, 1'b0, 1'b0);
        n_chk++; if (push_gnt !== 2'b01) begin n_fail++; $display("FAIL fullpop_next_gnt: got %b want 01", push_gnt); end
    endtask

    task automatic test_same_list();
        apply_reset();
        drive(2'b01, 1'b0, 1'b0);
        n_chk++; if (push_gnt !== 2'b01) begin n_fail++; $display("FAIL same_prefill: got %b want 01", push_gnt); end
        drive(2'b01, 1'b1, 1'b0);
        n_chk++; if (ll_push !== 1'b1 || ll_pop !== 1'b1 || ll_push_sel !== 1'b0 || ll_pop_sel !== 1'b0) begin n_fail++; $display("FAIL same_both: push=%b pop=%b psel=%b qsel=%b want 1/1/0/0", ll_push, ll_pop, ll_push_sel, ll_pop_sel); end
        drive(2'b00, 1'b1, 1'b0);
        n_chk++; if (pop_valid !== 1'b1 || pop_list !== 1'b0) begin n_fail++; $display("FAIL same_still_full: valid=%b list=%b want 1/0", pop_valid, pop_list); end
        drive(2'b00, 1'b1, 1'b0);
        n_chk++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL same_empty: valid=%b want 0", pop_valid); end
    endtask

    task automatic test_pop_rr();
        logic exp_list[4];
        exp_list = '{1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset();
        drive(2'b11, 1'b0, 1'b0);
        drive(2'b11, 1'b0, 1'b0);
        drive(2'b01, 1'b0, 1'b0);
        drive(2'b01, 1'b0, 1'b0);
        n_chk++; if (push_gnt !== 2'b01) begin n_fail++; $display("FAIL rr_fill_wrap: got %b want 01", push_gnt); end
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 1'b1, 1'b0);
            n_chk++; if (pop_valid !== 1'b1 || pop_list !== exp_list[k]) begin n_fail++; $display("FAIL rr_pop[%0d]: valid=%b list=%b want 1/%b", k, pop_valid, pop_list, exp_list[k]); end
        end
        drive(2'b00, 1'b1, 1'b0);
        n_chk++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drained: valid=%b want 0", pop_valid); end
    endtask

    task automatic test_drain();
        logic exp_list[3];
        exp_list = '{1'b0, 1'b1, 1'b0};
        apply_reset();
        drive(2'b11, 1'b0, 1'b0);
        drive(2'b11, 1'b0, 1'b0);
        drive(2'b01, 1'b0, 1'b0);
        drive(2'b00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 1'b1, 1'b1);
            n_chk++; if (push_gnt !== 2'b00 || pop_valid !== 1'b1 || pop_list !== exp_list[k] || drain_done !== 1'b0) begin n_fail++; $display("FAIL drain_pop[%0d]: gnt=%b valid=%b list=%b done=%b want 00/1/%b/0", k, push_gnt, pop_valid, pop_list, drain_done, exp_list[k]); end
        end
        drive(2'b11, 1'b1, 1'b1);
        n_chk++; if (push_gnt !== 2'b00 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle: gnt=%b valid=%b want 00/0", push_gnt, pop_valid); end
        drive(2'b11, 1'b1, 1'b1);
        n_chk++; if (drain_done !== 1'b1 || push_gnt !== 2'b00) begin n_fail++; $display("FAIL drain_done: done=%b gnt=%b want 1/00", drain_done, push_gnt); end
        drive(2'b11, 1'b1, 1'b0);
        n_chk++; if (drain_done !== 1'b1 || push_gnt !== 2'b00) begin n_fail++; $display("FAIL drain_release: done=%b gnt=%b want 1/00", drain_done, push_gnt); end
        drive(2'b11, 1'b0, 1'b0);
        n_chk++; if (drain_done !== 1'b0 || push_gnt !== 2'b10) begin n_fail++; $display("FAIL drain_resume: done=%b gnt=%b want 0/10", drain_done, push_gnt); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(2'b11, 1'b0, 1'b0);
        drive(2'b00, 1'b0, 1'b1);
        drive(2'b11, 1'b1, 1'b1);
        n_chk++; if (pop_valid !== 1'b1 || push_gnt !== 2'b00) begin n_fail++; $display("FAIL mid_pre: valid=%b gnt=%b want 1/00", pop_valid, push_gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (ll_pop !== 1'b0 || pop_valid !== 1'b0 || ll_push !== 1'b0 || push_gnt !== 2'b00 || drain_done !== 1'b0) begin n_fail++; $display("FAIL mid_async: pop=%b valid=%b push=%b gnt=%b done=%b want all 0", ll_pop, pop_valid, ll_push, push_gnt, drain_done); end
        @(negedge clk);
        rst_n = 1'b1; drain = 1'b0; pop_en = 1'b0; push_req = 2'b11;
        #1;
        n_chk++; if (push_gnt !== 2'b01 || drain_done !== 1'b0) begin n_fail++; $display("FAIL mid_first_gnt: gnt=%b done=%b want 01/0", push_gnt, drain_done); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_pop();
        test_same_list();
        test_pop_rr();
        test_drain();
        test_reset_mid();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
